// File: rtl/breakout_vga_renderer.sv
// 640x480@60 VGA timing plus Breakout scene renderer: brick grid, ball, paddle, background.
// The pixel path is two registered stages; hsync/vsync travel with RGB so all three stay aligned.
module breakout_vga_renderer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          ROWS         = 5,
  parameter int          COLS         = 5,
  parameter int          ADDR_W       = 6,
  parameter int          BLOCK_W      = 80,
  parameter int          BLOCK_H      = 30,
  parameter int          GAP_X        = 40,
  parameter int          GAP_Y        = 20,
  parameter int          ORIGIN_Y     = 40,
  parameter int          BALL_SIZE    = 8,
  parameter int          PADDLE_W     = 100,
  parameter int          PADDLE_H     = 10,
  parameter int          PADDLE_Y     = 440,
  parameter logic [47:0] ROW_COLORS   = {6'b111100, 6'b011001, 6'b010110, 6'b110011,
                                         6'b001111, 6'b111000, 6'b100101, 6'b101110},
  parameter logic [5:0]  BALL_COLOR   = 6'b101101,
  parameter logic [5:0]  PADDLE_COLOR = 6'b100001,
  parameter logic [5:0]  BG_COLOR     = 6'b000000
) (
  input  logic              CLK_25MH,
  input  logic              reset,
  output logic [5:0]        RGB,
  output logic              hsync,
  output logic              vsync,
  output logic [9:0]        hor_count,
  output logic [9:0]        ver_count,
  output logic              frame_start,
  input  logic [9:0]        paddle_pos,
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic              blk_we,
  input  logic [ADDR_W-1:0] blk_waddr,
  input  logic [1:0]        blk_wdata,
  input  logic [ADDR_W-1:0] blk_raddr,
  output logic [1:0]        blk_rdata,
  output logic [6:0]        bricks_left
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NUM_BRICKS = ROWS * COLS;
  localparam int DEPTH      = 2 ** ADDR_W;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_W:0]   NUM_A  = NUM_BRICKS[ADDR_W:0];
  localparam logic [6:0]        NUM_7  = NUM_BRICKS[6:0];
  localparam logic [ADDR_W-1:0] COLS_A = COLS[ADDR_W-1:0];
  localparam logic [1:0]        LVL_DEAD = 2'd3;

  // ---------------- timing counters ----------------
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hor_count   = hcount_q;
  assign ver_count   = vcount_q;
  assign frame_start = (hcount_q == '0) && (vcount_q == '0) && !reset;

  // Object positions only change on the very last pixel of a frame, so a frame never tears.
  logic [9:0] paddle_q, ball_x_q, ball_y_q;
  logic       frame_end;

  assign frame_end = (hcount_q == H_LAST) && (vcount_q == V_LAST);

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      paddle_q <= '0;
      ball_x_q <= '0;
      ball_y_q <= '0;
    end else if (frame_end) begin
      paddle_q <= paddle_pos;
      ball_x_q <= ball_x;
      ball_y_q <= ball_y;
    end
  end

  // ---------------- stage 1: region decode ----------------
  logic [10:0] x11, y11, bx11, by11, pp11;
  logic        hs1_d, vs1_d, vis1_d, ball1_d, paddle1_d, brick1_d;
  logic        col_hit, row_hit;
  logic [2:0]  col1_d, row1_d;
  logic [10:0] col_lo, row_lo;

  assign x11  = {1'b0, hcount_q};
  assign y11  = {1'b0, vcount_q};
  assign bx11 = {1'b0, ball_x_q};
  assign by11 = {1'b0, ball_y_q};
  assign pp11 = {1'b0, paddle_q};

  always_comb begin
    hs1_d  = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    vs1_d  = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    vis1_d = (hcount_q < H_VIS) && (vcount_q < V_VIS);

    col_hit = 1'b0;
    col1_d  = '0;
    col_lo  = '0;
    for (int c = 0; c < COLS; c++) begin
      col_lo = 11'(GAP_X + c * (GAP_X + BLOCK_W));
      if ((x11 >= col_lo) && (x11 < col_lo + 11'(BLOCK_W))) begin
        col_hit = 1'b1;
        col1_d  = 3'(c);
      end
    end

    row_hit = 1'b0;
    row1_d  = '0;
    row_lo  = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_lo = 11'(ORIGIN_Y + r * (GAP_Y + BLOCK_H));
      if ((y11 >= row_lo) && (y11 < row_lo + 11'(BLOCK_H))) begin
        row_hit = 1'b1;
        row1_d  = 3'(r);
      end
    end
    brick1_d = col_hit && row_hit;

    ball1_d   = (x11 >= bx11) && (x11 < bx11 + 11'(BALL_SIZE)) &&
                (y11 >= by11) && (y11 < by11 + 11'(BALL_SIZE));
    paddle1_d = (x11 >= pp11) && (x11 < pp11 + 11'(PADDLE_W)) &&
                (y11 >= 11'(PADDLE_Y)) && (y11 < 11'(PADDLE_Y + PADDLE_H));
  end

  logic       hs1_q, vs1_q, vis1_q, ball1_q, paddle1_q, brick1_q;
  logic [2:0] col1_q, row1_q;

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vis1_q    <= 1'b0;
      ball1_q   <= 1'b0;
      paddle1_q <= 1'b0;
      brick1_q  <= 1'b0;
      col1_q    <= '0;
      row1_q    <= '0;
    end else begin
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      vis1_q    <= vis1_d;
      ball1_q   <= ball1_d;
      paddle1_q <= paddle1_d;
      brick1_q  <= brick1_d;
      col1_q    <= col1_d;
      row1_q    <= row1_d;
    end
  end

  // ---------------- brick state RAM ----------------
  logic [1:0]        level_q [DEPTH];
  logic [1:0]        rdata_q;
  logic [6:0]        left_q, left_d;
  logic              wr_ok, rd_ok;
  logic [1:0]        old_lvl;

  assign wr_ok   = blk_we && ({1'b0, blk_waddr} < NUM_A);
  assign rd_ok   = {1'b0, blk_raddr} < NUM_A;
  assign old_lvl = level_q[blk_waddr];

  always_comb begin
    left_d = left_q;
    if (wr_ok) begin
      if ((old_lvl != LVL_DEAD) && (blk_wdata == LVL_DEAD) && (left_q != '0))
        left_d = left_q - 7'd1;
      else if ((old_lvl == LVL_DEAD) && (blk_wdata != LVL_DEAD) && (left_q != NUM_7))
        left_d = left_q + 7'd1;
    end
  end

  // NOTE: the level array is cleared entry by entry on reset, so it maps to flops, not a block RAM.
  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) level_q[i] <= '0;
      rdata_q <= '0;
      left_q  <= NUM_7;
    end else begin
      if (wr_ok) level_q[blk_waddr] <= blk_wdata;
      rdata_q <= rd_ok ? level_q[blk_raddr] : LVL_DEAD;
      left_q  <= left_d;
    end
  end

  assign blk_rdata   = rdata_q;
  assign bricks_left = left_q;

  // ---------------- stage 2: colour select ----------------
  logic [ADDR_W-1:0] brick_idx;
  logic [1:0]        brick_lvl;
  logic [5:0]        row_base, rgb_d;

  assign brick_idx = ADDR_W'(row1_q) * COLS_A + ADDR_W'(col1_q);
  assign brick_lvl = level_q[brick_idx];

  always_comb begin
    row_base = BG_COLOR;
    for (int r = 0; r < ROWS; r++)
      if (row1_q == 3'(r)) row_base = ROW_COLORS[6*r +: 6];

    rgb_d = BG_COLOR;
    if (!vis1_q)                              rgb_d = BG_COLOR;
    else if (paddle1_q)                       rgb_d = PADDLE_COLOR;
    else if (ball1_q)                         rgb_d = BALL_COLOR;
    else if (brick1_q && brick_lvl != LVL_DEAD) rgb_d = row_base + {4'b0000, brick_lvl};
  end

  logic [5:0] rgb_q;
  logic       hsync_q, vsync_q;

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      rgb_q   <= BG_COLOR;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign RGB   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_breakout_vga_renderer.sv
// Directed bench for breakout_vga_renderer: timing, brick grid colours, RAM ports,
// bricks_left bookkeeping, frame-latched ball/paddle and mid-line reset.
module tb_breakout_vga_renderer;

  localparam logic [5:0] C_ROW0   = 6'b101110;
  localparam logic [5:0] C_ROW1   = 6'b100101;
  localparam logic [5:0] C_ROW4   = 6'b110011;
  localparam logic [5:0] C_BALL   = 6'b101101;
  localparam logic [5:0] C_PADDLE = 6'b100001;
  localparam logic [5:0] C_BG     = 6'b000000;
  localparam int         BUDGET   = 430000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] RGB;
  logic       hsync, vsync, frame_start;
  logic [9:0] hor_count, ver_count;
  logic [9:0] paddle_pos, ball_x, ball_y;
  logic       blk_we;
  logic [5:0] blk_waddr, blk_raddr;
  logic [1:0] blk_wdata, blk_rdata;
  logic [6:0] bricks_left;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fs_count = 0;
  int t0 = 0;

  breakout_vga_renderer dut (
    .CLK_25MH    (clk),
    .reset       (reset),
    .RGB         (RGB),
    .hsync       (hsync),
    .vsync       (vsync),
    .hor_count   (hor_count),
    .ver_count   (ver_count),
    .frame_start (frame_start),
    .paddle_pos  (paddle_pos),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .blk_we      (blk_we),
    .blk_waddr   (blk_waddr),
    .blk_wdata   (blk_wdata),
    .blk_raddr   (blk_raddr),
    .blk_rdata   (blk_rdata),
    .bricks_left (bricks_left)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (frame_start === 1'b1) fs_count++;
  end

  // Advance on falling edges until the counters read (h,v); an expired budget is a failure.
  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(hor_count == 10'(h) && ver_count == 10'(v)) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      tests++;
      fails++;
      $display("FAIL wait_pos timeout waiting for (%0d,%0d) at (%0d,%0d)", h, v, hor_count, ver_count);
    end
  endtask

  // RGB carries pixel (x,y) while the counters read (x+2,y).
  task automatic probe(input int x, input int y, output logic [5:0] px);
    wait_pos(x + 2, y);
    px = RGB;
  endtask

  task automatic write_brick(input int a, input int d);
    blk_we    = 1'b1;
    blk_waddr = 6'(a);
    blk_wdata = 2'(d);
    @(negedge clk);
    blk_we    = 1'b0;
  endtask

  task automatic read_brick(input int a, output logic [1:0] d);
    blk_raddr = 6'(a);
    @(negedge clk);
    d = blk_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({hor_count, ver_count, RGB, hsync, vsync, frame_start, bricks_left, blk_rdata} !==
        {10'd0, 10'd0, C_BG, 1'b1, 1'b1, 1'b0, 7'd25, 2'd0}) begin
      fails++;
      $display("FAIL reset_state actual h=%0d v=%0d rgb=%b hs=%b vs=%b fs=%b left=%0d rd=%0d",
               hor_count, ver_count, RGB, hsync, vsync, frame_start, bricks_left, blk_rdata);
    end
    reset = 1'b0;
    #1;
    t0 = cyc;
    tests++;
    if (frame_start !== 1'b1) begin
      fails++;
      $display("FAIL frame_start_at_origin actual=%b expected=1", frame_start);
    end
  endtask

  task automatic test_hsync();
    int lows = 0;
    int first = -1;
    for (int i = 0; i < 800; i++) begin
      if (hsync === 1'b0) begin
        lows++;
        if (first < 0) first = int'(hor_count);
      end
      @(negedge clk);
    end
    tests++;
    if (lows != 96 || first != 658) begin
      fails++;
      $display("FAIL hsync_window actual lows=%0d first=%0d expected lows=96 first=658", lows, first);
    end
  endtask

  task automatic test_initial_ball();
    logic [5:0] px;
    probe(3, 3, px);
    tests++;
    if (px !== C_BALL) begin fails++; $display("FAIL ball_at_origin actual=%b expected=%b", px, C_BALL); end
    probe(8, 3, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL ball_right_edge actual=%b expected=%b", px, C_BG); end
  endtask

  task automatic test_brick_pixels();
    logic [5:0] px;
    probe(40, 39, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL above_row0 actual=%b expected=%b", px, C_BG); end
    probe(39, 40, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL left_of_col0 actual=%b expected=%b", px, C_BG); end
    probe(40, 40, px);
    tests++;
    if (px !== C_ROW0) begin fails++; $display("FAIL brick0_topleft actual=%b expected=%b", px, C_ROW0); end
    probe(120, 40, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL gap_after_col0 actual=%b expected=%b", px, C_BG); end
    probe(160, 40, px);
    tests++;
    if (px !== C_ROW0) begin fails++; $display("FAIL brick1_left actual=%b expected=%b", px, C_ROW0); end
    probe(119, 69, px);
    tests++;
    if (px !== C_ROW0) begin fails++; $display("FAIL brick0_botright actual=%b expected=%b", px, C_ROW0); end
    probe(40, 70, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL below_row0 actual=%b expected=%b", px, C_BG); end
    probe(40, 90, px);
    tests++;
    if (px !== C_ROW1) begin fails++; $display("FAIL row1_colour actual=%b expected=%b", px, C_ROW1); end
  endtask

  task automatic test_brick_write();
    logic [5:0] px;
    logic [1:0] d;
    wait_pos(0, 200);
    write_brick(20, 1);
    tests++;
    if (bricks_left !== 7'd25) begin fails++; $display("FAIL left_after_lvl1 actual=%0d expected=25", bricks_left); end
    read_brick(20, d);
    tests++;
    if (d !== 2'd1) begin fails++; $display("FAIL read_idx20 actual=%0d expected=1", d); end
    probe(40, 240, px);
    tests++;
    if (px !== 6'b110100) begin fails++; $display("FAIL row4_lvl1 actual=%b expected=%b", px, 6'b110100); end
    write_brick(20, 3);
    tests++;
    if (bricks_left !== 7'd24) begin fails++; $display("FAIL left_after_destroy actual=%0d expected=24", bricks_left); end
    probe(40, 250, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL destroyed_brick actual=%b expected=%b", px, C_BG); end
    write_brick(20, 3);
    tests++;
    if (bricks_left !== 7'd24) begin fails++; $display("FAIL left_rewrite3 actual=%0d expected=24", bricks_left); end
    write_brick(20, 0);
    tests++;
    if (bricks_left !== 7'd25) begin fails++; $display("FAIL left_restore actual=%0d expected=25", bricks_left); end
    write_brick(21, 2);
    probe(40, 260, px);
    tests++;
    if (px !== C_ROW4) begin fails++; $display("FAIL restored_brick actual=%b expected=%b", px, C_ROW4); end
    probe(160, 265, px);
    tests++;
    if (px !== 6'b110101) begin fails++; $display("FAIL row4_lvl2 actual=%b expected=%b", px, 6'b110101); end
    write_brick(21, 0);
  endtask

  task automatic test_oob_and_collision();
    logic [1:0] d;
    wait_pos(0, 280);
    write_brick(25, 3);
    tests++;
    if (bricks_left !== 7'd25) begin fails++; $display("FAIL oob_write_count actual=%0d expected=25", bricks_left); end
    read_brick(25, d);
    tests++;
    if (d !== 2'd3) begin fails++; $display("FAIL oob_read actual=%0d expected=3", d); end
    read_brick(24, d);
    tests++;
    if (d !== 2'd0) begin fails++; $display("FAIL idx24_untouched actual=%0d expected=0", d); end
    write_brick(3, 1);
    blk_we    = 1'b1;
    blk_waddr = 6'd3;
    blk_wdata = 2'd2;
    blk_raddr = 6'd3;
    @(negedge clk);
    blk_we = 1'b0;
    tests++;
    if (blk_rdata !== 2'd1) begin fails++; $display("FAIL collision_old_value actual=%0d expected=1", blk_rdata); end
    @(negedge clk);
    tests++;
    if (blk_rdata !== 2'd2) begin fails++; $display("FAIL collision_new_value actual=%0d expected=2", blk_rdata); end
    write_brick(3, 0);
  endtask

  task automatic test_latch_frame0();
    logic [5:0] px;
    wait_pos(0, 300);
    ball_x     = 10'd40;
    ball_y     = 10'd40;
    paddle_pos = 10'd300;
    probe(50, 441, px);
    tests++;
    if (px !== C_PADDLE) begin fails++; $display("FAIL old_paddle_kept actual=%b expected=%b", px, C_PADDLE); end
    probe(300, 442, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL new_paddle_early actual=%b expected=%b", px, C_BG); end
  endtask

  task automatic test_vsync();
    wait_pos(1, 490);
    tests++;
    if (vsync !== 1'b1) begin fails++; $display("FAIL vsync_before actual=%b expected=1", vsync); end
    @(negedge clk);
    tests++;
    if (vsync !== 1'b0) begin fails++; $display("FAIL vsync_start actual=%b expected=0", vsync); end
    wait_pos(1, 492);
    tests++;
    if (vsync !== 1'b0) begin fails++; $display("FAIL vsync_last actual=%b expected=0", vsync); end
    @(negedge clk);
    tests++;
    if (vsync !== 1'b1) begin fails++; $display("FAIL vsync_end actual=%b expected=1", vsync); end
  endtask

  task automatic test_frame_period();
    int n = 0;
    while (frame_start !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cyc - t0 != 420000) begin
      fails++;
      $display("FAIL frame_period actual=%0d expected=420000", cyc - t0);
    end
    // Only the first pulse has been sampled on a rising edge so far.
    tests++;
    if (fs_count != 1) begin fails++; $display("FAIL frame_start_pulses actual=%0d expected=1", fs_count); end
  endtask

  task automatic test_frame1();
    logic [5:0] px;
    probe(3, 3, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL old_ball_gone actual=%b expected=%b", px, C_BG); end
    probe(40, 40, px);
    tests++;
    if (px !== C_BALL) begin fails++; $display("FAIL ball_over_brick actual=%b expected=%b", px, C_BALL); end
    probe(47, 47, px);
    tests++;
    if (px !== C_BALL) begin fails++; $display("FAIL ball_corner actual=%b expected=%b", px, C_BALL); end
    probe(48, 47, px);
    tests++;
    if (px !== C_ROW0) begin fails++; $display("FAIL brick_past_ball actual=%b expected=%b", px, C_ROW0); end
    probe(300, 440, px);
    tests++;
    if (px !== C_PADDLE) begin fails++; $display("FAIL paddle_topleft actual=%b expected=%b", px, C_PADDLE); end
    probe(50, 441, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL old_paddle_gone actual=%b expected=%b", px, C_BG); end
    probe(399, 449, px);
    tests++;
    if (px !== C_PADDLE) begin fails++; $display("FAIL paddle_botright actual=%b expected=%b", px, C_PADDLE); end
    probe(400, 449, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL paddle_right_edge actual=%b expected=%b", px, C_BG); end
    probe(300, 450, px);
    tests++;
    if (px !== C_BG) begin fails++; $display("FAIL paddle_bottom_edge actual=%b expected=%b", px, C_BG); end
  endtask

  task automatic test_mid_reset();
    logic [5:0] px;
    logic [1:0] d;
    write_brick(0, 3);
    write_brick(1, 3);
    tests++;
    if (bricks_left !== 7'd23) begin fails++; $display("FAIL left_two_destroyed actual=%0d expected=23", bricks_left); end
    read_brick(1, d);
    tests++;
    if (d !== 2'd3) begin fails++; $display("FAIL read_destroyed actual=%0d expected=3", d); end
    wait_pos(400, 452);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({hor_count, ver_count, RGB, hsync, vsync, frame_start, bricks_left, blk_rdata} !==
        {10'd0, 10'd0, C_BG, 1'b1, 1'b1, 1'b0, 7'd25, 2'd0}) begin
      fails++;
      $display("FAIL midline_reset actual h=%0d v=%0d rgb=%b hs=%b vs=%b fs=%b left=%0d rd=%0d",
               hor_count, ver_count, RGB, hsync, vsync, frame_start, bricks_left, blk_rdata);
    end
    reset = 1'b0;
    read_brick(1, d);
    tests++;
    if (d !== 2'd0) begin fails++; $display("FAIL brick_cleared actual=%0d expected=0", d); end
    probe(40, 40, px);
    tests++;
    if (px !== C_ROW0) begin fails++; $display("FAIL brick0_after_reset actual=%b expected=%b", px, C_ROW0); end
  endtask

  initial begin
    reset      = 1'b1;
    paddle_pos = '0;
    ball_x     = '0;
    ball_y     = '0;
    blk_we     = 1'b0;
    blk_waddr  = '0;
    blk_wdata  = '0;
    blk_raddr  = '0;
    test_reset();
    test_hsync();
    test_initial_ball();
    test_brick_pixels();
    test_brick_write();
    test_oob_and_collision();
    test_latch_frame0();
    test_vsync();
    test_frame_period();
    test_frame1();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
